// File: rtl/serial_pkg.sv
// Shared definitions for the serial flit link: transmitter state encoding,
// line levels and the frame length helper.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      GAP
   } tx_state_e;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Cycles from START to STOP inclusive.
   function automatic int unsigned frame_len(input int unsigned flit_w,
                                             input int unsigned parity_en);
      return flit_w + ((parity_en != 0) ? 1 : 0) + 2;
   endfunction

endpackage

// File: rtl/serial_flit_tx.sv
// Parallel-to-serial flit transmitter: frames each accepted flit as
// START, data LSB first, optional even parity, STOP, then idle-high gap.
module serial_flit_tx #(
   parameter int unsigned FLIT_W    = 32,
   parameter int unsigned PARITY_EN = 1,
   parameter int unsigned GAP       = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] flit_i,
   input  logic              flit_valid_i,
   output logic              flit_ready_o,
   output logic              sflit_o,
   input  logic              sready_i,
   output logic              busy_o
);
   import serial_pkg::*;

   localparam int unsigned CNT_W = $clog2(FLIT_W);
   localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FLIT_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_e         state;
   logic [FLIT_W-1:0] shift_q;
   logic              parity_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              handshake;

   // Ready is forced low while reset is held so nothing is offered during reset.
   assign flit_ready_o = (state == IDLE) & sready_i & ~reset;
   assign handshake    = flit_valid_i & flit_ready_o;

   // Framing FSM; sflit_o and busy_o are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         sflit_o  <= IDLE_LVL;
         busy_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sflit_o <= IDLE_LVL;
               busy_o  <= 1'b0;
               if (handshake) begin
                  shift_q  <= flit_i;
                  parity_q <= ^flit_i;
                  bit_cnt  <= '0;
                  gap_cnt  <= '0;
                  state    <= START;
                  sflit_o  <= START_BIT;
                  busy_o   <= 1'b1;
               end
            end
            START: begin
               state   <= DATA;
               sflit_o <= shift_q[0];
               shift_q <= shift_q >> 1;
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  if (PARITY_EN != 0) begin
                     state   <= PARITY;
                     sflit_o <= parity_q;
                  end else begin
                     state   <= STOP;
                     sflit_o <= STOP_BIT;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  sflit_o <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            PARITY: begin
               state   <= STOP;
               sflit_o <= STOP_BIT;
            end
            STOP: begin
               sflit_o <= IDLE_LVL;
               if (GAP > 0) begin
                  state   <= serial_pkg::GAP;
                  gap_cnt <= '0;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            serial_pkg::GAP: begin
               sflit_o <= IDLE_LVL;
               if (gap_cnt == GAP_LAST) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               sflit_o <= IDLE_LVL;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_flit_tx.sv
// Bench for serial_flit_tx: frame-queue line model, receiving deserializers
// and directed stimulus on an 8-bit/parity/gap-1 and a 32-bit/no-parity/gap-0 instance.
module tb_serial_flit_tx;
   import serial_pkg::*;

   localparam int unsigned FW0 = 8;
   localparam int unsigned PE0 = 1;
   localparam int unsigned GP0 = 1;
   localparam int unsigned FW1 = 32;
   localparam int unsigned PE1 = 0;
   localparam int unsigned GP1 = 0;
   localparam int unsigned L0  = frame_len(FW0, PE0);
   localparam int unsigned L1  = frame_len(FW1, PE1);

   logic        clk;
   logic        reset;
   logic [7:0]  flit0;
   logic        valid0, sready0;
   logic        ready0, line0, busy0;
   logic [31:0] flit1;
   logic        valid1, sready1;
   logic        ready1, line1, busy1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic cmp_en = 1'b0;

   serial_flit_tx #(.FLIT_W(FW0), .PARITY_EN(PE0), .GAP(GP0)) dut0 (
      .clk(clk), .reset(reset), .flit_i(flit0), .flit_valid_i(valid0),
      .flit_ready_o(ready0), .sflit_o(line0), .sready_i(sready0), .busy_o(busy0));

   serial_flit_tx #(.FLIT_W(FW1), .PARITY_EN(PE1), .GAP(GP1)) dut1 (
      .clk(clk), .reset(reset), .flit_i(flit1), .flit_valid_i(valid1),
      .flit_ready_o(ready1), .sflit_o(line1), .sready_i(sready1), .busy_o(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line value at position idx of a frame followed by idle-high gap cycles.
   function automatic logic frame_bit(input logic [31:0] f, input int fw, input int pe, input int idx);
      logic p;
      p = 1'b0;
      for (int i = 0; i < fw; i++) p ^= f[i];
      if (idx == 0) return START_BIT;
      if (idx <= fw) return f[idx-1];
      if (pe != 0 && idx == fw + 1) return p;
      return STOP_BIT;
   endfunction

   // Model: an accepted flit enqueues its whole frame plus gap; the line
   // replays the queue one value per cycle and is busy while it is non-empty.
   logic        q0[$];
   logic        q1[$];
   logic [31:0] sent0[$];
   logic [31:0] sent1[$];
   logic        exp_line0 = 1'b1, exp_busy0 = 1'b0;
   logic        exp_line1 = 1'b1, exp_busy1 = 1'b0;
   int          acc0 = 0, acc1 = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q0.delete(); q1.delete();
         exp_line0 = 1'b1; exp_busy0 = 1'b0;
         exp_line1 = 1'b1; exp_busy1 = 1'b0;
      end else begin
         if (!exp_busy0 && sready0 && valid0) begin
            for (int i = 0; i < int'(L0 + GP0); i++) q0.push_back(frame_bit({24'h0, flit0}, FW0, PE0, i));
            sent0.push_back({24'h0, flit0});
            acc0++;
         end
         if (!exp_busy1 && sready1 && valid1) begin
            for (int i = 0; i < int'(L1 + GP1); i++) q1.push_back(frame_bit(flit1, FW1, PE1, i));
            sent1.push_back(flit1);
            acc1++;
         end
         if (q0.size() > 0) begin exp_line0 = q0.pop_front(); exp_busy0 = 1'b1; end
         else begin exp_line0 = 1'b1; exp_busy0 = 1'b0; end
         if (q1.size() > 0) begin exp_line1 = q1.pop_front(); exp_busy1 = 1'b1; end
         else begin exp_line1 = 1'b1; exp_busy1 = 1'b0; end
      end
   end

   // Per-cycle compare plus deserializers that rebuild flits from the line.
   int          ds0 = -1, ds1 = -1;
   logic [31:0] dd0, dd1;
   logic        dpar0;
   int          rx_idx0 = 0, rx_idx1 = 0;
   int          rx_cnt0 = 0, rx_cnt1 = 0;
   logic [31:0] rx_last0 = '0;
   logic        rx_par0 = 1'b1;
   int          start_q0[$];
   int          start_q1[$];

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("line0", line0, exp_line0);
         chk("busy0", busy0, exp_busy0);
         chk("ready0", ready0, !reset && !exp_busy0 && sready0);
         chk("line1", line1, exp_line1);
         chk("busy1", busy1, exp_busy1);
         chk("ready1", ready1, !reset && !exp_busy1 && sready1);
      end
      if (reset) begin
         ds0 = -1; ds1 = -1;
         rx_idx0 = sent0.size(); rx_idx1 = sent1.size();
      end else begin
         if (ds0 < 0) begin
            if (line0 == START_BIT) begin ds0 = 0; dd0 = '0; dpar0 = 1'b0; start_q0.push_back(cyc); end
         end else if (ds0 < int'(FW0)) begin
            dd0[ds0] = line0; ds0++;
         end else if (ds0 == int'(FW0)) begin
            dpar0 = line0; ds0++;
         end else begin
            chk("stop0", line0, STOP_BIT);
            chk("even_parity0", ^dd0 ^ dpar0, 1'b0);
            if (rx_idx0 < sent0.size()) chk("rx_flit0", dd0, sent0[rx_idx0]);
            else chk("rx_extra0", 32'(rx_idx0), 32'(sent0.size()));
            rx_idx0++; rx_cnt0++; rx_last0 = dd0; rx_par0 = dpar0; ds0 = -1;
         end
         if (ds1 < 0) begin
            if (line1 == START_BIT) begin ds1 = 0; dd1 = '0; start_q1.push_back(cyc); end
         end else if (ds1 < int'(FW1)) begin
            dd1[ds1] = line1; ds1++;
         end else begin
            chk("stop1", line1, STOP_BIT);
            if (rx_idx1 < sent1.size()) chk("rx_flit1", dd1, sent1[rx_idx1]);
            else chk("rx_extra1", 32'(rx_idx1), 32'(sent1.size()));
            rx_idx1++; rx_cnt1++; ds1 = -1;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_acc(input int which, input int target);
      int n;
      n = 0;
      while (((which == 0) ? acc0 : acc1) < target && n < 300) begin step(); n++; end
      chk("accept_timeout", 32'((((which == 0) ? acc0 : acc1) >= target) ? 1 : 0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   logic [10:0] a5_seq;
   int          rc, base1;

   initial begin
      a5_seq = 11'b10101001010;
      reset = 1'b1;
      valid0 = 1'b0; sready0 = 1'b1; flit0 = '0;
      valid1 = 1'b0; sready1 = 1'b1; flit1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_line0", line0, 1'b1);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_ready0", ready0, 1'b0);
      chk("rst_line1", line1, 1'b1);

      // First handshake on the first edge after reset release.
      flit0 = 8'hC3; valid0 = 1'b1; reset = 1'b0; cmp_en = 1'b1;
      step();
      valid0 = 1'b0;
      chk("first_hs_start", line0, START_BIT);
      chk("first_hs_busy", busy0, 1'b1);

      // Reset mid-frame drops the frame immediately.
      repeat (4) step();
      reset = 1'b1;
      #1;
      chk("midrst_line0", line0, 1'b1);
      chk("midrst_busy0", busy0, 1'b0);
      chk("midrst_ready0", ready0, 1'b0);
      step();
      reset = 1'b0;
      repeat (3) step();

      // Single 8'hA5 frame with literal line sequence.
      flit0 = 8'hA5; valid0 = 1'b1;
      step();
      valid0 = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         chk("a5_line", line0, a5_seq[k]);
         chk("a5_model", exp_line0, a5_seq[k]);
      end
      @(negedge clk); chk("a5_gap_busy", busy0, 1'b1);
      @(negedge clk); chk("a5_idle_busy", busy0, 1'b0);
      chk("a5_rx", rx_last0, 32'h0000_00A5);
      step(); step();

      // Back-to-back 01 then FF with valid held; next frame waits for IDLE.
      rc = rx_cnt0;
      flit0 = 8'h01; valid0 = 1'b1;
      wait_acc(0, acc0 + 1);
      flit0 = 8'hFF;
      wait_acc(0, acc0 + 1);
      valid0 = 1'b0;
      repeat (L0 + GP0 + 3) step();
      chk("b2b_count", 32'(rx_cnt0 - rc), 32'd2);
      chk("b2b_last", rx_last0, 32'h0000_00FF);
      chk("b2b_parity", rx_par0, 1'b0);
      chk("b2b_spacing", 32'(start_q0[start_q0.size()-1] - start_q0[start_q0.size()-2]), 32'(L0 + GP0 + 1));

      // sready low blocks the handshake.
      sready0 = 1'b0; flit0 = 8'h3C; valid0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("nrdy_line", line0, 1'b1);
         chk("nrdy_ready", ready0, 1'b0);
      end
      sready0 = 1'b1;
      step();
      valid0 = 1'b0;
      chk("rdy_start", line0, START_BIT);
      repeat (L0 + GP0 + 2) step();
      chk("rdy_rx", rx_last0, 32'h0000_003C);

      // Inputs disturbed mid-frame must not affect the frame.
      flit0 = 8'h5A; valid0 = 1'b1;
      step();
      for (int k = 0; k < 7; k++) begin
         sready0 = ~sready0;
         flit0 = 8'($urandom);
         step();
      end
      valid0 = 1'b0; sready0 = 1'b1;
      repeat (L0 + GP0 + 2) step();
      chk("disturb_rx", rx_last0, 32'h0000_005A);

      // 32-bit, no parity, no gap: 100 random flits back to back.
      base1 = start_q1.size();
      for (int i = 0; i < 100; i++) begin
         flit1 = $urandom;
         valid1 = 1'b1;
         wait_acc(1, i + 1);
      end
      valid1 = 1'b0;
      repeat (L1 + 4) step();
      chk("w32_count", 32'(rx_cnt1), 32'd100);
      for (int i = base1 + 1; i < start_q1.size(); i++)
         chk("w32_spacing", 32'(start_q1[i] - start_q1[i-1]), 32'(L1 + GP1 + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
